// File: rtl/dmem_video_arbiter.sv
// dmem_video_arbiter
//
// Shares the single-port data memory between the RISC-V core data port and
// the framebuffer scanout reader. The core always owns the memory when it is
// accessing it and sees zero added latency. Every other cycle is used to
// prefetch sequential framebuffer words into a small FIFO that the display
// timing logic drains.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   core_addr       core byte address (word address taken from [ADDR_W+1:2])
//   core_we         core store strobe
//   core_re         core load strobe
//   core_wdata      core store data
//   core_rdata      load data back to the core (RAM read data, unregistered)
//   mem_addr        word address to the RAM
//   mem_we          RAM write enable
//   mem_wdata       RAM write data
//   mem_rdata       RAM read data (asynchronous read of mem_addr)
//   vid_base        framebuffer base word address, static during a frame
//   vid_frame_start one-cycle pulse restarting scanout at vid_base
//   vid_pop         display consumes the FIFO head this cycle
//   vid_valid       FIFO non-empty
//   vid_data        FIFO head word
//   vid_underflow   saturating count of pops while the FIFO was empty
module dmem_video_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int FB_WORDS   = 300,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       core_addr,
    input  logic              core_we,
    input  logic              core_re,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic [ADDR_W-1:0] vid_base,
    input  logic              vid_frame_start,
    input  logic              vid_pop,
    output logic              vid_valid,
    output logic [31:0]       vid_data,
    output logic [7:0]        vid_underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(FB_WORDS);

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [OFF_W-1:0]  offset;
    logic [7:0]        underflow;

    logic              core_busy;
    logic              pop_ok;
    logic              pop_empty;
    logic              fetch;
    logic [ADDR_W-1:0] fb_addr;

    // Byte-offset and high address bits are not decoded by this memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[31:ADDR_W+2], core_addr[1:0]};

    assign core_busy = core_we | core_re;
    assign pop_ok    = vid_pop & (count != '0);
    // A pop discarded by a frame restart is not an underflow.
    assign pop_empty = vid_pop & (count == '0) & ~vid_frame_start;

    // Fetch into a free slot, or into the slot a valid pop frees this cycle.
    assign fetch = ~core_busy & ~reset & ~vid_frame_start &
                   ((count < CNT_W'(FIFO_DEPTH)) | pop_ok);

    assign fb_addr = vid_base + ADDR_W'(offset);

    assign mem_addr   = core_busy ? core_addr[ADDR_W+1:2] : fb_addr;
    assign mem_we     = core_we & ~reset;
    assign mem_wdata  = core_wdata;
    assign core_rdata = mem_rdata;

    assign vid_valid     = (count != '0);
    assign vid_data      = fifo_mem[rd_ptr];
    assign vid_underflow = underflow;

    // FIFO storage is data only; it is never cleared.
    always_ff @(posedge clk) begin
        if (fetch) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            offset    <= '0;
            underflow <= '0;
        end else if (vid_frame_start) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            offset <= '0;
        end else begin
            if (fetch) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                offset <= (offset == OFF_W'(FB_WORDS - 1)) ? '0 : offset + OFF_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fetch, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop_empty && underflow != 8'hFF) begin
                underflow <= underflow + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_video_arbiter.sv
module tb_dmem_video_arbiter;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset;
    logic [31:0]       core_addr;
    logic              core_we;
    logic              core_re;
    logic [31:0]       core_wdata;
    logic [31:0]       core_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] vid_base;
    logic              vid_frame_start;
    logic              vid_pop;
    logic              vid_valid;
    logic [31:0]       vid_data;
    logic [7:0]        vid_underflow;

    logic [31:0] ram [1024];

    int total;
    int passed;
    int failed;

    dmem_video_arbiter #(
        .ADDR_W(ADDR_W),
        .FB_WORDS(300),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_addr(core_addr),
        .core_we(core_we),
        .core_re(core_re),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .vid_base(vid_base),
        .vid_frame_start(vid_frame_start),
        .vid_pop(vid_pop),
        .vid_valid(vid_valid),
        .vid_data(vid_data),
        .vid_underflow(vid_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: asynchronous read, synchronous write.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        for (int i = 0; i < 1024; i++) ram[i] <= pat(i);

        reset           = 1'b1;
        core_addr       = 32'h0;
        core_we         = 1'b0;
        core_re         = 1'b0;
        core_wdata      = 32'h0;
        vid_base        = 10'h100;
        vid_frame_start = 1'b0;
        vid_pop         = 1'b0;
        step();
        step();

        // Reset state
        check("rst_valid", 32'(vid_valid), 32'd0);
        check("rst_underflow", 32'(vid_underflow), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);

        // 1: prefetch fill from an idle core
        reset = 1'b0;
        #1;
        check("t1_addr0", 32'(mem_addr), 32'h100);
        check("t1_valid0", 32'(vid_valid), 32'd0);
        check("t1_we0", 32'(mem_we), 32'd0);
        step();
        check("t1_valid1", 32'(vid_valid), 32'd1);
        check("t1_data1", vid_data, pat(32'h100));
        check("t1_addr1", 32'(mem_addr), 32'h101);
        step();
        check("t1_addr2", 32'(mem_addr), 32'h102);
        step();
        check("t1_addr3", 32'(mem_addr), 32'h103);
        step();
        check("t1_addr_full", 32'(mem_addr), 32'h104);
        step();
        check("t1_addr_held", 32'(mem_addr), 32'h104);
        check("t1_data_held", vid_data, pat(32'h100));

        // 2: core store with a pop in the same cycle
        core_we    = 1'b1;
        core_addr  = 32'h40;
        core_wdata = 32'hDEADBEEF;
        vid_pop    = 1'b1;
        #1;
        check("t2_addr", 32'(mem_addr), 32'h10);
        check("t2_we", 32'(mem_we), 32'd1);
        check("t2_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        core_we = 1'b0;
        vid_pop = 1'b0;
        #1;
        check("t2_ram", ram[16], 32'hDEADBEEF);
        check("t2_head", vid_data, pat(32'h101));
        check("t2_fetch_addr", 32'(mem_addr), 32'h104);
        step();
        check("t2_next_addr", 32'(mem_addr), 32'h105);
        step();
        check("t2_full_addr", 32'(mem_addr), 32'h105);

        // 3: continuous pops across the framebuffer wrap
        vid_pop = 1'b1;
        #1;
        for (int k = 1; k <= 301; k++) begin
            check($sformatf("t3_data%0d", k), vid_data, pat(32'h100 + (k % 300)));
            check($sformatf("t3_valid%0d", k), 32'(vid_valid), 32'd1);
            step();
        end
        vid_pop = 1'b0;
        #1;
        check("t3_head_after", vid_data, pat(32'h102));
        check("t3_addr_after", 32'(mem_addr), 32'h106);

        // 4: core loads every cycle while the display drains and underflows
        core_re = 1'b1;
        vid_pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            core_addr = 32'h8000_0040 + 32'(4 * i);
            #1;
            check($sformatf("t4_addr%0d", i), 32'(mem_addr), 32'h10 + 32'(i));
            check($sformatf("t4_rdata%0d", i), core_rdata,
                  (i == 0) ? 32'hDEADBEEF : pat(32'h10 + i));
            check($sformatf("t4_valid%0d", i), 32'(vid_valid), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) check($sformatf("t4_data%0d", i), vid_data, pat(32'h102 + i));
            step();
        end
        core_re = 1'b0;
        vid_pop = 1'b0;
        #1;
        check("t4_underflow", 32'(vid_underflow), 32'd6);
        check("t4_fetch_addr", 32'(mem_addr), 32'h106);

        // 5: frame restart with count 3 and offset 57, pop in the same cycle
        for (int i = 0; i < 4; i++) step();
        vid_pop = 1'b1;
        for (int i = 0; i < 47; i++) step();
        core_re   = 1'b1;
        core_addr = 32'h0;
        step();
        core_re         = 1'b0;
        vid_frame_start = 1'b1;
        #1;
        check("t5_head_before", vid_data, pat(32'h136));
        check("t5_addr_before", 32'(mem_addr), 32'h139);
        check("t5_valid_before", 32'(vid_valid), 32'd1);
        step();
        vid_frame_start = 1'b0;
        vid_pop         = 1'b0;
        #1;
        check("t5_valid_after", 32'(vid_valid), 32'd0);
        check("t5_underflow", 32'(vid_underflow), 32'd6);
        check("t5_restart_addr", 32'(mem_addr), 32'h100);
        step();
        check("t5_valid_refill", 32'(vid_valid), 32'd1);
        check("t5_data_refill", vid_data, pat(32'h100));

        // 6: reset mid-stream with a core store pending
        reset      = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h44;
        core_wdata = 32'h1234_5678;
        #1;
        check("t6_mem_we", 32'(mem_we), 32'd0);
        step();
        check("t6_valid", 32'(vid_valid), 32'd0);
        check("t6_underflow", 32'(vid_underflow), 32'd0);
        check("t6_ram_kept", ram[17], pat(32'h11));
        reset   = 1'b0;
        core_we = 1'b0;
        #1;
        check("t6_addr", 32'(mem_addr), 32'h100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
